// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: bounded-burst round-robin sharing of one FIFO write port among N producers; FIFO_ARB_PRIO0_EN makes requester 0 high priority
module fifo_wr_arbiter #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N-1:0]              req,
   input  logic [N*DATA_WIDTH-1:0]   req_data,
   output logic [N-1:0]              gnt,
   input  logic                      fifo_full,
   output logic                      fifo_w_en,
   output logic [DATA_WIDTH-1:0]     fifo_data_in,
   output logic [$clog2(N)-1:0]      owner,
   output logic                      owner_valid
);
   localparam int W  = $clog2(N);
   localparam int BW = $clog2(BURST) + 1;
   localparam logic [BW-1:0] BMAX = BW'(BURST);

   logic [BW-1:0] burst_cnt, bump;
   logic [W-1:0]  rr_ptr, rr_sel, idx, sel, nxt_ptr;
   logic          found, cont, p0, acc, same;

   // first requester at or after rr_ptr, modulo N
   always_comb begin
      rr_sel = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx = W'((int'(rr_ptr) + k) % N);
         if (!found && req[idx]) begin
            rr_sel = idx;
            found  = 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_PRIO0_EN
   assign p0 = req[0];
`else
   assign p0 = 1'b0;
`endif

   assign cont    = owner_valid && req[owner] && burst_cnt < BMAX;
   assign sel     = p0 ? '0 : cont ? owner : rr_sel;
   assign acc     = !rst && !fifo_full && (p0 || cont || found);
   assign same    = owner_valid && sel == owner;
   assign bump    = burst_cnt + 1'b1;
   assign nxt_ptr = (sel == W'(N - 1)) ? '0 : sel + 1'b1;

   // grant and FIFO write are combinational so ownership changes cost no cycle
   always_comb begin
      gnt          = acc ? N'(1) << sel : '0;
      fifo_w_en    = acc;
      fifo_data_in = acc ? req_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

   // ownership, burst budget and round-robin pointer; full stalls hold everything except release-on-drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner       <= '0;
         owner_valid <= 1'b0;
         burst_cnt   <= '0;
         rr_ptr      <= '0;
      end else if (acc) begin
         if (!p0)
            rr_ptr <= nxt_ptr;
         if (same) begin
            burst_cnt   <= bump;
            owner_valid <= bump != BMAX;
         end else begin
            owner       <= sel;
            burst_cnt   <= BW'(1);
            owner_valid <= BMAX != BW'(1);
         end
      end else if (owner_valid && !req[owner]) begin
         owner_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven directed check of the bounded-burst write arbiter
module tb_fifo_wr_arbiter;
   logic        clk = 0, rst = 1, fifo_full = 0, fifo_w_en, owner_valid;
   logic [3:0]  req = '0, gnt;
   logic [31:0] req_data;
   logic [7:0]  fifo_data_in;
   logic [1:0]  owner;
   logic [7:0]  cnt [4];
   logic [7:0]  base [4] = '{8'h10, 8'h50, 8'hA0, 8'hE0};
   int          total = 0, passed = 0;

   typedef struct {
      logic [3:0] req;
      logic       full;
      logic [3:0] gnt;
      logic [7:0] dout;
      logic [1:0] own;
      logic       ov;
   } vec_t;
   vec_t v[$];

   fifo_wr_arbiter #(.N(4), .DATA_WIDTH(8), .BURST(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
      .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in),
      .owner(owner), .owner_valid(owner_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < 4; i++) cnt[i] <= '0;
      else for (int i = 0; i < 4; i++) cnt[i] <= cnt[i] + {7'd0, gnt[i]};

   always_comb
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base[i] + cnt[i];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void add(logic [3:0] r, logic f, logic [3:0] g, logic [7:0] d, logic [1:0] o, logic ov);
      vec_t x;
      x.req = r; x.full = f; x.gnt = g; x.dout = d; x.own = o; x.ov = ov;
      v.push_back(x);
   endfunction

   task automatic run(input int a, input int b);
      for (int i = a; i < b; i++) begin
         req = v[i].req;
         fifo_full = v[i].full;
         #2;
         chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(v[i].gnt));
         chk($sformatf("row%0d w_en", i), 32'(fifo_w_en), 32'(|v[i].gnt));
         chk($sformatf("row%0d data", i), 32'(fifo_data_in), 32'(v[i].dout));
         @(posedge clk); #1;
         chk($sformatf("row%0d owner", i), 32'(owner), 32'(v[i].own));
         chk($sformatf("row%0d owner_valid", i), 32'(owner_valid), 32'(v[i].ov));
      end
   endtask

   task automatic do_reset();
      rst = 1; req = '0; fifo_full = 0;
      @(posedge clk); #1;
      rst = 0;
   endtask

   int s2, s3, s4, s5, s6, s7;
   logic prio;

   initial begin
`ifdef FIFO_ARB_PRIO0_EN
      prio = 1;
`else
      prio = 0;
`endif
      s2 = v.size();
      for (int i = 0; i < 6; i++) add(4'b0100, 0, 4'b0100, 8'hA0 + 8'(i), 2'd2, i != 3);
      s3 = v.size();
      for (int i = 0; i < 16; i++) begin
         int r;
         r = prio ? 0 : i / 4;
         add(4'b1111, 0, 4'b0001 << r, base[r] + 8'(prio ? i : i % 4), 2'(r), (i % 4) != 3);
      end
      for (int i = 0; i < 2; i++) add(4'b1111, 1, 4'b0000, 8'h00, prio ? 2'd0 : 2'd3, 0);
      s4 = v.size();
      add(4'b0011, 0, 4'b0001, 8'h10, 0, 1);
      add(4'b0011, 0, 4'b0001, 8'h11, 0, 1);
      for (int i = 0; i < 3; i++) add(4'b0011, 1, 4'b0000, 8'h00, 0, 1);
      add(4'b0011, 0, 4'b0001, 8'h12, 0, 1);
      add(4'b0011, 0, 4'b0001, 8'h13, 0, 0);
      if (prio) add(4'b0011, 0, 4'b0001, 8'h14, 0, 1);
      else      add(4'b0011, 0, 4'b0010, 8'h50, 1, 1);
      s5 = v.size();
      add(4'b0010, 0, 4'b0010, 8'h50, 1, 1);
      add(4'b1000, 0, 4'b1000, 8'hE0, 3, 1);
      s6 = v.size();
      add(4'b0100, 0, 4'b0100, 8'hA0, 2, 1);
      add(4'b0100, 0, 4'b0100, 8'hA1, 2, 1);
      s7 = v.size();
      add(4'b0100, 0, 4'b0100, 8'hA0, 2, 1);

      // outputs forced low while reset is held with all requests up
      rst = 1; req = 4'b1111;
      #3;
      chk("rst gnt", 32'(gnt), 0);
      chk("rst w_en", 32'(fifo_w_en), 0);
      chk("rst data", 32'(fifo_data_in), 0);
      @(posedge clk); #1;
      rst = 0;
      #2;
      chk("first gnt", 32'(gnt), 32'h1);
      chk("first data", 32'(fifo_data_in), 32'h10);
      @(posedge clk); #1;
      chk("first owner", 32'(owner), 0);

      do_reset(); run(s2, s3);
      do_reset(); run(s3, s4);
      do_reset(); run(s4, s5);
      do_reset(); run(s5, s6);
      do_reset(); run(s6, s7);

      // asynchronous reset in the middle of requester 2's burst
      req = 4'b0101;
      #2;
      rst = 1;
      #1;
      chk("midrst gnt", 32'(gnt), 0);
      chk("midrst w_en", 32'(fifo_w_en), 0);
      chk("midrst data", 32'(fifo_data_in), 0);
      chk("midrst owner", 32'(owner), 0);
      chk("midrst owner_valid", 32'(owner_valid), 0);
      @(posedge clk); #1;
      rst = 0;
      #2;
      chk("post-rst gnt", 32'(gnt), 32'h1);
      chk("post-rst data", 32'(fifo_data_in), 32'h10);
      @(posedge clk); #1;
      chk("post-rst owner", 32'(owner), 0);
      run(s7, v.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of synchronous_fifo among N producers.
- Round-robin arbitration with bounded bursts: a granted producer may write up to BURST consecutive words before ownership rotates.
- Sits directly in front of the FIFO: drives w_en/data_in and observes full.
- Selection is combinational from registered state, so there is no dead cycle between owners.

Parameters:
- N, 4, number of requesters (2..8).
- DATA_WIDTH, 8, word width; matches the FIFO.
- BURST, 4, max consecutive accepted words per ownership (>=1); 1 gives per-word round robin.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-requester write request; word valid on req_data.
- req_data  in  N*DATA_WIDTH  packed words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  N  one-hot/zero; gnt[i]=1 means requester i's word is written at this edge; requester advances its data next cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable; equals |gnt.
- fifo_data_in  out  DATA_WIDTH  word of the selected requester; 0 when no grant.
- owner  out  clog2(N)  current owner index (debug).
- owner_valid  out  1  a burst is in progress.

Behaviour:
- Registered state:
  - owner, reset 0.
  - owner_valid, reset 0.
  - burst_cnt, width clog2(BURST)+1, reset 0.
  - rr_ptr, reset 0.
- While rst=1: gnt=0, fifo_w_en=0, fifo_data_in=0. Outputs are forced, not only the state.
- Selection each cycle (combinational):
  - Continue burst if owner_valid && req[owner] && burst_cnt<BURST: sel=owner.
  - Otherwise sel = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... mod N.
  - No req set: no selection, all outputs 0.
- Accept: gnt[sel] = req[sel] && !fifo_full. fifo_w_en and fifo_data_in follow the same cycle, giving zero-latency handshake.
- On accept edge:
  - If sel==owner && owner_valid: burst_cnt++.
  - Otherwise: owner<=sel, owner_valid<=1, burst_cnt<=1.
  - rr_ptr<=(sel+1) mod N.
  - If the new burst_cnt==BURST: owner_valid<=0 (rotate next cycle).
- Owner release without accept: owner_valid && !req[owner] causes owner_valid<=0. A new owner may be accepted in that same cycle via the rr search, so there is no bubble.
- fifo_full=1:
  - No grant; burst_cnt, rr_ptr and owner are held.
  - Full stalls do not consume burst budget.
  - Release-on-drop still applies while full.
- Wrap-around: the rr search and rr_ptr arithmetic are modulo N. rr_ptr after requester N-1 is 0.
- Requesters must hold req and req_data stable until granted. Behaviour when req drops before grant: the requester is simply skipped.
- Reset mid-burst: all state cleared immediately (async); the first pick after release starts from requester 0.
- The arbiter never writes when fifo_full=1. FIFO overflow is impossible by construction.

Optional Feature:
- Macro FIFO_ARB_PRIO0_EN.
- Defined:
  - Requester 0 is high priority. When req[0]=1 and the current owner is not 0, the burst is pre-empted at the next selection: sel=0 that cycle.
  - The pre-empted owner's owner_valid clears. rr_ptr is not updated by requester-0 accepts, so the round-robin order among 1..N-1 is preserved.
- Undefined: pure bounded-burst round robin as above; requester 0 has no special treatment.

Test Plan (N=4, DATA_WIDTH=8, BURST=4, FIFO DEPTH=16):
1. rst=1 with req=4'b1111, full=0: gnt=0, fifo_w_en=0. After release: gnt=4'b0001 on the first cycle, owner=0.
2. Only req[2] high for 6 words (0xA0..0xA5), full=0:
   - gnt[2] high 4 cycles, then owner_valid=0 for 0 cycles of bubble. The burst restarts with requester 2 since it is the only requester.
   - Six FIFO writes in order 0xA0..0xA5.
3. req=4'b1111 continuous, FIFO draining off:
   - Grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3.
   - fifo_full asserts after 16 writes; gnt=0 thereafter.
4. Requester 0 accepted 2 words, then fifo_full=1 for 3 cycles with req=4'b0011: no writes during stall. After stall requester 0 writes exactly 2 more words, then gnt[1].
5. Owner 1 drops req after 1 word while req[3]=1, req[2]=0: gnt[3] in the very next cycle, owner=3, burst_cnt=1.
6. rst pulsed mid-burst (owner=2, burst_cnt=2) with req=4'b0101: outputs 0 during rst; after release gnt[0] first, rr_ptr reset. With FIFO_ARB_PRIO0_EN, repeat scenario 3 holding req[0]: requester 0 granted every cycle.
